tile_ram_writer: RTL and testbench
==================================

// Module: tile_ram_writer
// PURPOSE
//  Write-side engine for the text/tile RAM that the VGA bit generator scans.
//  Accepts single-cell, rectangle-fill and clear-screen commands from the CPU/IO side.
//  Emits one RAM write per cycle in row-major order, clipped to the screen grid.
//  Data words pass through verbatim: bit15=1 is a solid RGB555 tile, bit15=0 is a glyph index in [13:0].
// PARAMETERS
//  COLS    80  tile columns per row (RAM row stride)
//  ROWS    60  tile rows on screen
//  ADDR_W  14  RAM address width
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       engine idle; command accepted when cmd_valid && cmd_ready at posedge
//  cmd_op     in   2       0=single write, 1=fill rect, 2=clear screen, 3=reserved (treated as no-op)
//  cmd_x0     in   7       start column
//  cmd_y0     in   6       start row
//  cmd_w      in   7       rect width in cells (op 1 only)
//  cmd_h      in   6       rect height in cells (op 1 only)
//  cmd_data   in   16      word written to every target cell
//  vblank     in   1       write window; present only with TRW_VBLANK_GATE_EN
//  ram_we     out  1       RAM write enable (registered)
//  ram_addr   out  ADDR_W  RAM write address (registered)
//  ram_wdata  out  16      RAM write data (registered)
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse when a command completes
// BEHAVIOUR
//  - Reset: state=IDLE; ram_we=0, ram_addr=0, ram_wdata=0, done=0, busy=0, cmd_ready=1.
//  - Reset mid-command aborts it: no write after the reset edge, and no done pulse.
//  - cmd_ready = (state==IDLE). Inputs are latched only on the accept edge.
//  - Inputs offered while busy are ignored.
//  - States:
//    - IDLE -> SETUP on accept.
//    - SETUP (1 cycle) normalises the command:
//      - op0: w=h=1.
//      - op2: x0=0, y0=0, w=COLS, h=ROWS.
//      - Clips: w_eff=min(w,COLS-x0), h_eff=min(h,ROWS-y0).
//      - Computes base=x0+COLS*y0 (shift-add, no multiplier).
//      - If x0>=COLS, y0>=ROWS, w_eff==0, h_eff==0 or op==3 -> DONE with zero writes.
//      - Otherwise -> WRITE, loading ram_addr=base, ram_wdata=data, ram_we=1.
//    - WRITE: one write per cycle.
//      - Column advance: ram_addr+1.
//      - After the last column of a row: ram_addr=row_base+COLS, and row_base updates.
//      - After the final cell: ram_we=0 -> DONE.
//    - DONE: done=1 for exactly one cycle -> IDLE.
//  - Latency, with the accept edge as E0:
//    - First write is visible after E1.
//    - Write k (0-based) is visible after E(1+k).
//    - done is visible after E(1+N), where N=w_eff*h_eff.
//    - cmd_ready is high again after E(2+N).
//    - Zero-write commands: done after E1, ready after E2.
//  - Address arithmetic is ADDR_W bits wide. Max address is COLS*ROWS-1=4799 and never wraps.
//  - Back-to-back: a new command can be accepted in the cycle cmd_ready returns high.
// CONFIGURATION
//  TRW_VBLANK_GATE_EN defined:
//    - vblank port exists.
//    - In WRITE with vblank=0: ram_we=0, address and counters frozen. Resumes on the same cell when vblank=1.
//    - SETUP and DONE are not gated.
//  TRW_VBLANK_GATE_EN undefined:
//    - No vblank port; writes run every cycle as above.
// TESTING
//  T1 op0 x0=5 y0=2 data=16'h0041 -> single write addr=165, data=16'h0041; done after E2; ready after E3.
//  T2 op1 x0=78 y0=0 w=4 h=2 data=16'hFC00 -> writes 78,79,158,159 in order; done after E5.
//  T3 op2 data=16'h0000 -> 4800 writes, addrs 0..4799 consecutive; done after E4801; no addr>4799.
//  T4 op1 x0=80 y0=3 w=5 h=5 -> no ram_we; done after E1. Also op1 w=0 -> same.
//  T5 op1 x0=0 y0=0 w=10 h=10, reset asserted after 7th write -> no further writes, no done, ready=1 after reset.
//  T6 (TRW_VBLANK_GATE_EN) op1 x0=0 y0=0 w=3 h=1, vblank low for 4 cycles after 1st write -> writes 0,1,2 with none during the gap, no duplicates.

Source files
------------

// File: rtl/tile_ram_writer.sv
// Tile RAM write engine: expands single/rect/clear commands into row-major RAM writes, clipped to the grid.
// Latency: first write registered one cycle after accept, one write per cycle, done one cycle after the last write.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored. Optional vblank stall in WRITE.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/x0/y0/w/h/data latched on the accept edge
//   vblank                write window (only when TRW_VBLANK_GATE_EN is defined)
//   ram_we/addr/wdata     registered RAM write port
//   busy, done            status: busy outside IDLE, done pulses one cycle on completion
//
// Configuration macro: TRW_VBLANK_GATE_EN -- adds the vblank port and stalls writes while vblank is low.

module tile_ram_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [6:0]        cmd_x0,
    input  logic [5:0]        cmd_y0,
    input  logic [6:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [15:0]       cmd_data,
`ifdef TRW_VBLANK_GATE_EN
    input  logic              vblank,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] OP_SINGLE = 2'd0;
    localparam logic [1:0] OP_FILL   = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_NOP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  x0;
        logic [5:0]  y0;
        logic [6:0]  w;
        logic [5:0]  h;
        logic [15:0] data;
    } cmd_t;

    // Row offset y*COLS built from shifted copies of COLS, one per set bit of y.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [5:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            if (y[i]) begin
                acc = acc + (ADDR_W'(COLS) << i);
            end
        end
        return acc;
    endfunction

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_wdata_q, ram_wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic [6:0]        w_eff_q, w_eff_d;
    logic [5:0]        h_eff_q, h_eff_d;

    // Write window; always open when the vblank gate is not built in.
    logic wr_win;
`ifdef TRW_VBLANK_GATE_EN
    assign wr_win = vblank;
`else
    assign wr_win = 1'b1;
`endif

    // Command normalisation and clipping, evaluated from the latched command during SETUP.
    logic [6:0]        x_n;
    logic [5:0]        y_n;
    logic [6:0]        w_n;
    logic [5:0]        h_n;
    logic              x_in, y_in;
    logic [7:0]        cols_left;
    logic [6:0]        rows_left;
    logic [6:0]        w_clip;
    logic [5:0]        h_clip;
    logic [ADDR_W-1:0] base;
    logic              no_writes;

    always_comb begin
        x_n = cmd_q.x0;
        y_n = cmd_q.y0;
        w_n = cmd_q.w;
        h_n = cmd_q.h;
        if (cmd_q.op == OP_SINGLE) begin
            w_n = 7'd1;
            h_n = 6'd1;
        end else if (cmd_q.op == OP_CLEAR) begin
            x_n = 7'd0;
            y_n = 6'd0;
            w_n = 7'(COLS);
            h_n = 6'(ROWS);
        end

        x_in      = ({1'b0, x_n} < 8'(COLS));
        y_in      = ({1'b0, y_n} < 7'(ROWS));
        // Only meaningful when the start cell is on screen; otherwise no_writes wins.
        cols_left = 8'(COLS) - {1'b0, x_n};
        rows_left = 7'(ROWS) - {1'b0, y_n};
        w_clip    = ({1'b0, w_n} < cols_left) ? w_n : cols_left[6:0];
        h_clip    = ({1'b0, h_n} < rows_left) ? h_n : rows_left[5:0];
        base      = ADDR_W'(x_n) + row_offset(y_n);
        no_writes = (cmd_q.op == OP_NOP) || !x_in || !y_in ||
                    (w_clip == 7'd0) || (h_clip == 6'd0);
    end

    logic last_col, last_row;
    assign last_col = (col_q == w_eff_q - 7'd1);
    assign last_row = (row_q == h_eff_q - 6'd1);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        done_d      = 1'b0;
        row_base_d  = row_base_q;
        col_d       = col_q;
        row_d       = row_q;
        w_eff_d     = w_eff_q;
        h_eff_d     = h_eff_q;

        case (state_q)
            ST_IDLE: begin
                ram_we_d = 1'b0;
                if (cmd_valid) begin
                    cmd_d.op   = cmd_op;
                    cmd_d.x0   = cmd_x0;
                    cmd_d.y0   = cmd_y0;
                    cmd_d.w    = cmd_w;
                    cmd_d.h    = cmd_h;
                    cmd_d.data = cmd_data;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (no_writes) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = ST_WRITE;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = base;
                    ram_wdata_d = cmd_q.data;
                    row_base_d  = base;
                    col_d       = 7'd0;
                    row_d       = 6'd0;
                    w_eff_d     = w_clip;
                    h_eff_d     = h_clip;
                end
            end
            ST_WRITE: begin
                // ram_addr_q is the cell being written whenever ram_we_q is high; advance
                // only past a cell that was actually written, so a stall never skips or repeats.
                if (ram_we_q) begin
                    if (last_col && last_row) begin
                        ram_we_d = 1'b0;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else if (last_col) begin
                        ram_we_d   = wr_win;
                        col_d      = 7'd0;
                        row_d      = row_q + 6'd1;
                        row_base_d = row_base_q + ADDR_W'(COLS);
                        ram_addr_d = row_base_q + ADDR_W'(COLS);
                    end else begin
                        ram_we_d   = wr_win;
                        col_d      = col_q + 7'd1;
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                    end
                end else begin
                    ram_we_d = wr_win;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
            row_base_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            w_eff_q     <= '0;
            h_eff_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_q      <= done_d;
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
            w_eff_q     <= w_eff_d;
            h_eff_q     <= h_eff_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tile_ram_writer.sv
// Directed bench for tile_ram_writer: single write, clipped fill, clear screen,
// zero-write commands, reset abort and (when built with the gate) vblank stalling.
// All expected values are hand-computed constants.

module tb_tile_ram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x0;
    logic [5:0]  cmd_y0;
    logic [6:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [15:0] cmd_data;
`ifdef TRW_VBLANK_GATE_EN
    logic        vblank;
`endif
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    tile_ram_writer #(.COLS(80), .ROWS(60), .ADDR_W(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_data  (cmd_data),
`ifdef TRW_VBLANK_GATE_EN
        .vblank    (vblank),
`endif
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Results of the last run_cmd call.
    logic [13:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          done_k;
    logic        busy_at1;
    logic        rdy_at_done;
    logic        rdy_after;
    logic        done_after;

    // Issue one command at a negedge, accept edge is E0; sample #1 after each edge Ek.
    // With hold_busy the bench keeps offering a different command while the engine is busy.
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] x0, input logic [5:0] y0,
                           input logic [6:0] w, input logic [5:0] h, input logic [15:0] data,
                           input bit hold_busy);
        @(negedge clk);
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold_busy) begin
            cmd_op = 2'd0; cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_data = 16'hDEAD;
        end else begin
            cmd_valid = 1'b0;
        end
        wr_addr.delete();
        wr_data.delete();
        done_k   = -1;
        busy_at1 = 1'b0;
        for (int k = 1; k <= 6000 && done_k < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) busy_at1 = busy;
            if (ram_we) begin
                wr_addr.push_back(ram_addr);
                wr_data.push_back(ram_wdata);
            end
            if (done) begin
                done_k      = k;
                rdy_at_done = cmd_ready;
                cmd_valid   = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rdy_after  = cmd_ready;
        done_after = done;
    endtask

    int   nwr;
    int   ndone;
    logic consec;
    logic data_ok;
    logic [13:0] max_addr;
    int   wr_k[$];

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_w = 7'd0; cmd_h = 6'd0; cmd_data = 16'd0;
`ifdef TRW_VBLANK_GATE_EN
        vblank = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",    32'(ram_we),    32'd0);
        chk("rst_addr",  32'(ram_addr),  32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // T1: single cell at (5,2) -> 5 + 2*80 = 165.
        run_cmd(2'd0, 7'd5, 6'd2, 7'd9, 6'd9, 16'h0041, 1'b0);
        chk("t1_nwr",    32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t1_addr", 32'(wr_addr[0]), 32'd165);
            chk("t1_data", 32'(wr_data[0]), 32'h0041);
        end
        chk("t1_busy",     32'(busy_at1),    32'd1);
        chk("t1_done_k",   32'(done_k),      32'd2);
        chk("t1_rdy_done", 32'(rdy_at_done), 32'd0);
        chk("t1_rdy_E3",   32'(rdy_after),   32'd1);
        chk("t1_done_1cy", 32'(done_after),  32'd0);

        // T2: fill clipped at the right edge, offered junk held while busy.
        run_cmd(2'd1, 7'd78, 6'd0, 7'd4, 6'd2, 16'hFC00, 1'b1);
        chk("t2_nwr", 32'(wr_addr.size()), 32'd4);
        if (wr_addr.size() == 4) begin
            chk("t2_a0", 32'(wr_addr[0]), 32'd78);
            chk("t2_a1", 32'(wr_addr[1]), 32'd79);
            chk("t2_a2", 32'(wr_addr[2]), 32'd158);
            chk("t2_a3", 32'(wr_addr[3]), 32'd159);
            chk("t2_d3", 32'(wr_data[3]), 32'hFC00);
        end
        chk("t2_done_k", 32'(done_k),    32'd5);
        chk("t2_rdy",    32'(rdy_after), 32'd1);

        // T3: clear screen; x0/y0/w/h fields must be ignored.
        run_cmd(2'd2, 7'd33, 6'd7, 7'd1, 6'd1, 16'h0000, 1'b0);
        consec   = 1'b1;
        data_ok  = 1'b1;
        max_addr = '0;
        foreach (wr_addr[i]) begin
            if (wr_addr[i] != 14'(i)) consec = 1'b0;
            if (wr_data[i] != 16'h0000) data_ok = 1'b0;
            if (wr_addr[i] > max_addr) max_addr = wr_addr[i];
        end
        chk("t3_nwr",    32'(wr_addr.size()), 32'd4800);
        chk("t3_consec", 32'(consec),         32'd1);
        chk("t3_data",   32'(data_ok),        32'd1);
        chk("t3_max",    32'(max_addr),       32'd4799);
        chk("t3_done_k", 32'(done_k),         32'd4801);
        chk("t3_rdy",    32'(rdy_after),      32'd1);

        // T4: zero-write commands.
        run_cmd(2'd1, 7'd80, 6'd3, 7'd5, 6'd5, 16'h1234, 1'b0);
        chk("t4a_nwr",    32'(wr_addr.size()), 32'd0);
        chk("t4a_done_k", 32'(done_k),         32'd1);
        chk("t4a_rdy",    32'(rdy_after),      32'd1);
        run_cmd(2'd1, 7'd10, 6'd10, 7'd0, 6'd4, 16'h1234, 1'b0);
        chk("t4b_nwr",    32'(wr_addr.size()), 32'd0);
        chk("t4b_done_k", 32'(done_k),         32'd1);
        run_cmd(2'd1, 7'd10, 6'd60, 7'd3, 6'd3, 16'h1234, 1'b0);
        chk("t4c_nwr",    32'(wr_addr.size()), 32'd0);
        run_cmd(2'd3, 7'd1, 6'd1, 7'd3, 6'd3, 16'h1234, 1'b0);
        chk("t4d_nwr",    32'(wr_addr.size()), 32'd0);
        chk("t4d_done_k", 32'(done_k),         32'd1);

        // Bottom-right corner clip: only cell 79 + 59*80 = 4799.
        run_cmd(2'd1, 7'd79, 6'd59, 7'd5, 6'd5, 16'h8001, 1'b0);
        chk("corner_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) chk("corner_addr", 32'(wr_addr[0]), 32'd4799);
        chk("corner_done_k", 32'(done_k), 32'd2);

        // T5: reset after the 7th write of a 10x10 fill.
        @(negedge clk);
        cmd_op = 2'd1; cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_w = 7'd10; cmd_h = 6'd10; cmd_data = 16'h7777;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        nwr = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (ram_we) nwr++;
        end
        chk("t5_nwr_before", 32'(nwr), 32'd7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_we_rst_edge", 32'(ram_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nwr   = 0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (ram_we) nwr++;
            if (done) ndone++;
        end
        chk("t5_nwr_after", 32'(nwr),       32'd0);
        chk("t5_no_done",   32'(ndone),     32'd0);
        chk("t5_ready",     32'(cmd_ready), 32'd1);
        chk("t5_busy",      32'(busy),      32'd0);

`ifdef TRW_VBLANK_GATE_EN
        // T6: vblank low for 4 cycles right after the first write.
        @(negedge clk);
        cmd_op = 2'd1; cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_w = 7'd3; cmd_h = 6'd1; cmd_data = 16'h00AA;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wr_addr.delete();
        wr_k.delete();
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ram_we) begin
                wr_addr.push_back(ram_addr);
                wr_k.push_back(k);
            end
            if (done) ndone++;
            if (k == 1) vblank = 1'b0;
            if (k == 5) vblank = 1'b1;
        end
        chk("t6_nwr", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t6_a0", 32'(wr_addr[0]), 32'd0);
            chk("t6_a1", 32'(wr_addr[1]), 32'd1);
            chk("t6_a2", 32'(wr_addr[2]), 32'd2);
            chk("t6_k0", 32'(wr_k[0]),    32'd1);
            chk("t6_gap", 32'(wr_k[1] > 5), 32'd1);
        end
        chk("t6_done", 32'(ndone), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
